fpu_ss_commit_buffer: RTL and testbench

// - Parametrised in-order buffer between CV-X-IF issue and FPU_SS execute. Holds accepted

---
 rtl/fpu_ss_commit_buffer.sv | 192 +++++++++++++++++++
 tb/tb_fpu_ss_commit_buffer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_ss_commit_buffer.sv
// fpu_ss_commit_buffer
// In-order buffer between the CV-X-IF issue interface and the FPU_SS execute stage.
// It holds accepted offloaded instructions until the core commits or kills them.
// Committed entries leave in program order. A killed entry is dropped when it reaches
// the head, and a one-cycle kill pulse reports its id so the scoreboard can free it.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   in_valid_i / in_ready_o       issue-side handshake
//   in_id_i, in_instr_i, in_mode_i, in_rs_i   entry fields (rs[0] in the LSBs)
//   commit_valid_i, commit_id_i, commit_kill_i   commit or kill strobe for one id
//   out_valid_o / out_ready_i     execute-side handshake for the committed head
//   out_id_o, out_instr_o, out_mode_o, out_rs_o  head entry fields
//   kill_valid_o, kill_id_o       pulse raised when a killed head is discarded
//   count_o                       number of occupied entries
//
// Configuration macro FPU_SS_COMMIT_BYPASS_EN: when the buffer is empty and the entry
// being pushed is committed (not killed) in the same cycle, that entry goes straight to
// out_*. If out_ready_i is also high, the entry is never stored.

module fpu_ss_commit_buffer #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned NUM_RS     = 3,
   parameter int unsigned RFR_WIDTH  = 32,
   parameter int unsigned MODE_WIDTH = 2
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          in_valid_i,
   output logic                          in_ready_o,
   input  logic [ID_WIDTH-1:0]           in_id_i,
   input  logic [31:0]                   in_instr_i,
   input  logic [MODE_WIDTH-1:0]         in_mode_i,
   input  logic [NUM_RS*RFR_WIDTH-1:0]   in_rs_i,
   input  logic                          commit_valid_i,
   input  logic [ID_WIDTH-1:0]           commit_id_i,
   input  logic                          commit_kill_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [ID_WIDTH-1:0]           out_id_o,
   output logic [31:0]                   out_instr_o,
   output logic [MODE_WIDTH-1:0]         out_mode_o,
   output logic [NUM_RS*RFR_WIDTH-1:0]   out_rs_o,
   output logic                          kill_valid_o,
   output logic [ID_WIDTH-1:0]           kill_id_o,
   output logic [$clog2(DEPTH):0]        count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned RS_W  = NUM_RS * RFR_WIDTH;

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [CNT_W-1:0] cnt_t;

   logic [ID_WIDTH-1:0]   id_q    [DEPTH];
   logic [ID_WIDTH-1:0]   id_d    [DEPTH];
   logic [31:0]           instr_q [DEPTH];
   logic [31:0]           instr_d [DEPTH];
   logic [MODE_WIDTH-1:0] mode_q  [DEPTH];
   logic [MODE_WIDTH-1:0] mode_d  [DEPTH];
   logic [RS_W-1:0]       rs_q    [DEPTH];
   logic [RS_W-1:0]       rs_d    [DEPTH];
   logic [DEPTH-1:0]      valid_q, valid_d;
   logic [DEPTH-1:0]      cmt_q, cmt_d;
   logic [DEPTH-1:0]      kill_q, kill_d;

   ptr_t                  wr_ptr_q, wr_ptr_d;
   ptr_t                  rd_ptr_q, rd_ptr_d;
   cnt_t                  count_q, count_d;
   logic                  kill_valid_q, kill_valid_d;
   logic [ID_WIDTH-1:0]   kill_id_q, kill_id_d;

   logic head_out, head_disc, push, in_match, bypass, pop, store, remove;

   // Pop and discard decisions use registered flags only, so a commit always costs
   // one cycle before the entry can leave.
   assign head_out   = valid_q[rd_ptr_q] && cmt_q[rd_ptr_q] && !kill_q[rd_ptr_q];
   assign head_disc  = valid_q[rd_ptr_q] && cmt_q[rd_ptr_q] &&  kill_q[rd_ptr_q];
   // No same-cycle pop bypass: readiness depends on occupancy only.
   assign in_ready_o = !rst_i && (count_q < cnt_t'(DEPTH));
   assign push       = in_valid_i && in_ready_o;
   assign in_match   = commit_valid_i && (commit_id_i == in_id_i);

`ifdef FPU_SS_COMMIT_BYPASS_EN
   assign bypass = (count_q == '0) && push && in_match && !commit_kill_i;
`else
   assign bypass = 1'b0;
`endif

   assign pop    = head_out && out_ready_i;
   assign store  = push && !(bypass && out_ready_i);
   assign remove = pop || head_disc;

   always_comb begin
      out_valid_o = head_out || bypass;
      out_id_o    = bypass ? in_id_i    : id_q[rd_ptr_q];
      out_instr_o = bypass ? in_instr_i : instr_q[rd_ptr_q];
      out_mode_o  = bypass ? in_mode_i  : mode_q[rd_ptr_q];
      out_rs_o    = bypass ? in_rs_i    : rs_q[rd_ptr_q];
   end

   always_comb begin
      id_d         = id_q;
      instr_d      = instr_q;
      mode_d       = mode_q;
      rs_d         = rs_q;
      valid_d      = valid_q;
      cmt_d        = cmt_q;
      kill_d       = kill_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      kill_valid_d = head_disc;
      kill_id_d    = head_disc ? id_q[rd_ptr_q] : kill_id_q;

      for (int i = 0; i < DEPTH; i++) begin
         if (commit_valid_i && valid_q[ptr_t'(i)] && (id_q[ptr_t'(i)] == commit_id_i)) begin
            cmt_d[ptr_t'(i)] = 1'b1;
            if (commit_kill_i) kill_d[ptr_t'(i)] = 1'b1;
         end
      end

      if (remove) begin
         valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d          = rd_ptr_q + ptr_t'(1);
      end

      // A write never lands on the slot being removed: when full no push is accepted,
      // and when empty there is nothing to remove.
      if (store) begin
         valid_d[wr_ptr_q] = 1'b1;
         id_d[wr_ptr_q]    = in_id_i;
         instr_d[wr_ptr_q] = in_instr_i;
         mode_d[wr_ptr_q]  = in_mode_i;
         rs_d[wr_ptr_q]    = in_rs_i;
         cmt_d[wr_ptr_q]   = in_match;
         kill_d[wr_ptr_q]  = in_match && commit_kill_i;
         wr_ptr_d          = wr_ptr_q + ptr_t'(1);
      end

      count_d = count_q + cnt_t'(store) - cnt_t'(remove);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q      <= '0;
         cmt_q        <= '0;
         kill_q       <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         kill_valid_q <= 1'b0;
         kill_id_q    <= '0;
      end else begin
         valid_q      <= valid_d;
         cmt_q        <= cmt_d;
         kill_q       <= kill_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         kill_valid_q <= kill_valid_d;
         kill_id_q    <= kill_id_d;
      end
   end

   // Payload needs no reset; it is qualified by valid_q.
   always_ff @(posedge clk_i) begin
      id_q    <= id_d;
      instr_q <= instr_d;
      mode_q  <= mode_d;
      rs_q    <= rs_d;
   end

   assign kill_valid_o = kill_valid_q;
   assign kill_id_o    = kill_id_q;
   assign count_o      = count_q;

`ifndef SYNTHESIS
   // Ids must be unique among resident entries; the head leaving this cycle may be reused.
   always_ff @(posedge clk_i) begin
      if (!rst_i && store) begin
         for (int i = 0; i < DEPTH; i++) begin
            assert (!(valid_q[ptr_t'(i)] && (id_q[ptr_t'(i)] == in_id_i) &&
                      !(remove && (ptr_t'(i) == rd_ptr_q))))
               else $error("duplicate id pushed into commit buffer");
         end
      end
   end
`endif

endmodule

// File: tb/tb_fpu_ss_commit_buffer.sv
module tb_fpu_ss_commit_buffer;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [3:0]  in_id_i;
   logic [31:0] in_instr_i;
   logic [1:0]  in_mode_i;
   logic [95:0] in_rs_i;
   logic        commit_valid_i;
   logic [3:0]  commit_id_i;
   logic        commit_kill_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [3:0]  out_id_o;
   logic [31:0] out_instr_o;
   logic [1:0]  out_mode_o;
   logic [95:0] out_rs_o;
   logic        kill_valid_o;
   logic [3:0]  kill_id_o;
   logic [2:0]  count_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk_i = ~clk_i;

   fpu_ss_commit_buffer #(.DEPTH(4), .ID_WIDTH(4), .NUM_RS(3), .RFR_WIDTH(32), .MODE_WIDTH(2)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_id_i(in_id_i),
      .in_instr_i(in_instr_i), .in_mode_i(in_mode_i), .in_rs_i(in_rs_i),
      .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_id_o(out_id_o),
      .out_instr_o(out_instr_o), .out_mode_o(out_mode_o), .out_rs_o(out_rs_o),
      .kill_valid_o(kill_valid_o), .kill_id_o(kill_id_o), .count_o(count_o)
   );

   typedef struct {
      bit         rst, iv, cv, ck, ordy;
      logic [3:0] iid, cid;
      bit         e_rdy, e_ov, e_kv;
      logic [3:0] e_oid, e_kid;
      logic [2:0] e_cnt;
   } vec_t;

   typedef struct {
      logic [3:0]  id;
      logic [31:0] instr;
      logic [1:0]  mode;
      logic [95:0] rs;
      bit          cmt, kill;
   } ent_t;

   vec_t vt[$];
   ent_t mq[$];

   function automatic logic [31:0] instr_of(input logic [3:0] id);
      return {28'hF00D_A5C, id};
   endfunction
   function automatic logic [1:0] mode_of(input logic [3:0] id);
      return id[1:0] ^ 2'b10;
   endfunction
   function automatic logic [95:0] rs_of(input logic [3:0] id);
      return {28'h3000_000, id, 28'h2000_000, id, 28'h1000_000, id};
   endfunction

   function automatic vec_t mk(bit rst, bit iv, logic [3:0] iid, bit cv, logic [3:0] cid, bit ck,
                               bit ordy, bit e_rdy, bit e_ov, logic [3:0] e_oid, bit e_kv,
                               logic [3:0] e_kid, logic [2:0] e_cnt);
      vec_t v;
      v.rst = rst; v.iv = iv; v.iid = iid; v.cv = cv; v.cid = cid; v.ck = ck; v.ordy = ordy;
      v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_oid = e_oid; v.e_kv = e_kv; v.e_kid = e_kid;
      v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_idle();
      rst_i = 1'b0; in_valid_i = 1'b0; in_id_i = '0; in_instr_i = '0; in_mode_i = '0;
      in_rs_i = '0; commit_valid_i = 1'b0; commit_id_i = '0; commit_kill_i = 1'b0;
      out_ready_i = 1'b0;
   endtask

   task automatic drive_push(input logic [3:0] id);
      in_valid_i = 1'b1; in_id_i = id; in_instr_i = instr_of(id);
      in_mode_i = mode_of(id); in_rs_i = rs_of(id);
   endtask

   task automatic drive_commit(input logic [3:0] id, input bit kill);
      commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
   endtask

   task automatic chk_head(input string nm, input logic [3:0] id);
      chk({nm, "_out_valid"}, 128'(out_valid_o), 128'(1));
      chk({nm, "_out_id"},    128'(out_id_o),    128'(id));
      chk({nm, "_out_instr"}, 128'(out_instr_o), 128'(instr_of(id)));
      chk({nm, "_out_mode"},  128'(out_mode_o),  128'(mode_of(id)));
      chk({nm, "_out_rs"},    128'(out_rs_o),    128'(rs_of(id)));
   endtask

   initial begin
      bit         exp_rdy, exp_ov, exp_kv, byp, push, match, nkv;
      logic [3:0] exp_kid, nkid;
      ent_t       eh, ne;

      set_idle();
      rst_i = 1'b1;
      repeat (2) cyc();

      // rst | iv iid | cv cid ck | ordy || rdy ov oid kv kid cnt
      vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vt.push_back(mk(0, 1, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      vt.push_back(mk(0, 0, 0, 1, 3, 0, 0, 1, 0, 0, 0, 0, 1));
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 3, 0, 0, 1));
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      vt.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      vt.push_back(mk(0, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
      vt.push_back(mk(0, 1, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2));
      vt.push_back(mk(0, 0, 0, 1, 2, 1, 0, 1, 0, 0, 0, 0, 3));
      vt.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 3));
      vt.push_back(mk(0, 0, 0, 1, 3, 0, 1, 1, 1, 1, 0, 0, 3));
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2));
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 3, 1, 2, 1));
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
`ifdef FPU_SS_COMMIT_BYPASS_EN
      vt.push_back(mk(0, 1, 5, 1, 5, 0, 1, 1, 1, 5, 0, 0, 0));
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
`else
      vt.push_back(mk(0, 1, 5, 1, 5, 0, 1, 1, 0, 0, 0, 0, 0));
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 5, 0, 0, 1));
`endif
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

      foreach (vt[k]) begin
         set_idle();
         rst_i = vt[k].rst;
         if (vt[k].iv) drive_push(vt[k].iid);
         if (vt[k].cv) drive_commit(vt[k].cid, vt[k].ck);
         out_ready_i = vt[k].ordy;
         #2;
         chk($sformatf("vec%0d_in_ready", k), 128'(in_ready_o), 128'(vt[k].e_rdy));
         chk($sformatf("vec%0d_out_valid", k), 128'(out_valid_o), 128'(vt[k].e_ov));
         chk($sformatf("vec%0d_kill_valid", k), 128'(kill_valid_o), 128'(vt[k].e_kv));
         chk($sformatf("vec%0d_count", k), 128'(count_o), 128'(vt[k].e_cnt));
         if (vt[k].e_ov) chk_head($sformatf("vec%0d", k), vt[k].e_oid);
         if (vt[k].e_kv) chk($sformatf("vec%0d_kill_id", k), 128'(kill_id_o), 128'(vt[k].e_kid));
         cyc();
      end

      // Fill to capacity, then a pop with a push offered in the same cycle.
      set_idle(); drive_push(4'd1); cyc();
      set_idle(); drive_push(4'd2); cyc();
      set_idle(); drive_push(4'd4); cyc();
      set_idle(); drive_push(4'd6); cyc();
      set_idle(); drive_commit(4'd1, 1'b0); #2;
      chk("full_in_ready", 128'(in_ready_o), 128'(0));
      chk("full_count", 128'(count_o), 128'(4));
      cyc();
      set_idle(); drive_push(4'd7); out_ready_i = 1'b1; #2;
      chk("full_pop_in_ready", 128'(in_ready_o), 128'(0));
      chk_head("full_pop", 4'd1);
      cyc();
      set_idle(); drive_push(4'd7); #2;
      chk("retry_in_ready", 128'(in_ready_o), 128'(1));
      chk("retry_count", 128'(count_o), 128'(3));
      cyc();
      set_idle(); drive_commit(4'd2, 1'b0); #2;
      chk("refill_count", 128'(count_o), 128'(4));
      chk("refill_out_valid", 128'(out_valid_o), 128'(0));
      cyc();

      // Committed head held while out_ready_i is low; a commit for an absent id is ignored.
      for (int c = 0; c < 5; c++) begin
         set_idle();
         if (c == 1) drive_commit(4'd9, 1'b1);
         #2;
         chk_head($sformatf("hold%0d", c), 4'd2);
         chk($sformatf("hold%0d_count", c), 128'(count_o), 128'(4));
         chk($sformatf("hold%0d_kill_valid", c), 128'(kill_valid_o), 128'(0));
         cyc();
      end

      set_idle(); out_ready_i = 1'b1; cyc();
      set_idle(); drive_commit(4'd4, 1'b0); #2;
      chk("pre_rst_count", 128'(count_o), 128'(3));
      cyc();
      set_idle(); rst_i = 1'b1; #2;
      chk("rst_in_ready_low", 128'(in_ready_o), 128'(0));
      cyc();
      set_idle(); #2;
      chk("post_rst_count", 128'(count_o), 128'(0));
      chk("post_rst_out_valid", 128'(out_valid_o), 128'(0));
      chk("post_rst_kill_valid", 128'(kill_valid_o), 128'(0));
      chk("post_rst_kill_id", 128'(kill_id_o), 128'(0));
      chk("post_rst_in_ready", 128'(in_ready_o), 128'(1));
      cyc();

      // Randomised traffic against a queue model of the buffer.
      mq.delete();
      exp_kv = 1'b0;
      exp_kid = '0;
      for (int c = 0; c < 800; c++) begin
         set_idle();
         if ($urandom_range(0, 99) < 60) begin
            logic [3:0] cand;
            bit clash;
            do begin
               cand  = 4'($urandom_range(0, 15));
               clash = 1'b0;
               foreach (mq[j]) if (mq[j].id == cand) clash = 1'b1;
            end while (clash);
            in_valid_i = 1'b1; in_id_i = cand; in_instr_i = $urandom;
            in_mode_i = 2'($urandom_range(0, 3));
            in_rs_i = {$urandom, $urandom, $urandom};
         end
         if ($urandom_range(0, 99) < 45) begin
            commit_valid_i = 1'b1;
            commit_kill_i  = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
               0, 1:    commit_id_i = (mq.size() > 0) ?
                                      mq[$urandom_range(0, mq.size() - 1)].id : in_id_i;
               2:       commit_id_i = in_id_i;
               default: commit_id_i = 4'($urandom_range(0, 15));
            endcase
         end
         out_ready_i = ($urandom_range(0, 99) < 65);
         #2;

         exp_rdy = (mq.size() < 4);
         push    = in_valid_i && exp_rdy;
         match   = commit_valid_i && (commit_id_i == in_id_i);
`ifdef FPU_SS_COMMIT_BYPASS_EN
         byp = (mq.size() == 0) && push && match && !commit_kill_i;
`else
         byp = 1'b0;
`endif
         exp_ov = 1'b0;
         if (byp) begin
            exp_ov = 1'b1;
            eh.id = in_id_i; eh.instr = in_instr_i; eh.mode = in_mode_i; eh.rs = in_rs_i;
         end else if (mq.size() > 0 && mq[0].cmt && !mq[0].kill) begin
            exp_ov = 1'b1;
            eh = mq[0];
         end

         chk("rnd_in_ready", 128'(in_ready_o), 128'(exp_rdy));
         chk("rnd_out_valid", 128'(out_valid_o), 128'(exp_ov));
         chk("rnd_count", 128'(count_o), 128'(mq.size()));
         chk("rnd_kill_valid", 128'(kill_valid_o), 128'(exp_kv));
         chk("rnd_kill_id", 128'(kill_id_o), 128'(exp_kid));
         if (exp_ov) begin
            chk("rnd_out_id", 128'(out_id_o), 128'(eh.id));
            chk("rnd_out_instr", 128'(out_instr_o), 128'(eh.instr));
            chk("rnd_out_mode", 128'(out_mode_o), 128'(eh.mode));
            chk("rnd_out_rs", 128'(out_rs_o), 128'(eh.rs));
         end

         // Head leaves based on flags set before this cycle's commit.
         nkv = 1'b0;
         nkid = exp_kid;
         if (mq.size() > 0 && mq[0].cmt) begin
            if (mq[0].kill) begin
               nkv = 1'b1;
               nkid = mq[0].id;
               void'(mq.pop_front());
            end else if (out_ready_i) begin
               void'(mq.pop_front());
            end
         end
         if (commit_valid_i)
            for (int j = 0; j < mq.size(); j++)
               if (mq[j].id == commit_id_i) begin
                  mq[j].cmt = 1'b1;
                  if (commit_kill_i) mq[j].kill = 1'b1;
               end
         if (push && !(byp && out_ready_i)) begin
            ne.id = in_id_i; ne.instr = in_instr_i; ne.mode = in_mode_i; ne.rs = in_rs_i;
            ne.cmt = match; ne.kill = match && commit_kill_i;
            mq.push_back(ne);
         end
         exp_kv = nkv;
         exp_kid = nkid;
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
